// File: rtl/alu_dispatch_ctrl.sv
// -----------------------------------------------------------------------------
// alu_dispatch_ctrl
//
// Accepts one ALU request at a time and dispatches it to one of NUM_UNITS
// execution units. The upper UNIT_SEL_WIDTH bits of ALU_FUN select the unit and
// the remaining low bits are forwarded as the sub-operation. The controller
// holds the unit enable while it waits for that unit's completion, aborting
// with a timeout pulse if the unit does not respond within TIMEOUT_CYCLES.
//
// Ports
//   CLK          in   clock, rising edge
//   RST          in   asynchronous reset, active low
//   ALU_FUN      in   {unit select, sub-op}
//   ALU_EN       in   request valid
//   Enable_Mask  in   per-unit dispatch permission
//   Unit_Done    in   per-unit completion, level sampled
//   Req_Ready    out  high only while idle; request taken on ALU_EN & Req_Ready
//   Unit_Enable  out  registered one-hot enable of the active unit
//   Unit_OP      out  registered sub-op of the accepted request
//   OUT_VALID    out  one-cycle pulse, operation completed
//   Timeout_Err  out  one-cycle pulse, operation aborted by timeout
//   Illegal_Op   out  one-cycle pulse, request targeted a masked unit
// -----------------------------------------------------------------------------
module alu_dispatch_ctrl #(
    parameter int unsigned ALU_FUN_WIDTH  = 4,
    parameter int unsigned UNIT_SEL_WIDTH = 2,
    parameter int unsigned TIMEOUT_CYCLES = 8
) (
    input  logic                                      CLK,
    input  logic                                      RST,
    input  logic [ALU_FUN_WIDTH-1:0]                  ALU_FUN,
    input  logic                                      ALU_EN,
    input  logic [(1<<UNIT_SEL_WIDTH)-1:0]            Enable_Mask,
    input  logic [(1<<UNIT_SEL_WIDTH)-1:0]            Unit_Done,
    output logic                                      Req_Ready,
    output logic [(1<<UNIT_SEL_WIDTH)-1:0]            Unit_Enable,
    output logic [ALU_FUN_WIDTH-UNIT_SEL_WIDTH-1:0]   Unit_OP,
    output logic                                      OUT_VALID,
    output logic                                      Timeout_Err,
    output logic                                      Illegal_Op
);

    localparam int unsigned NUM_UNITS = 1 << UNIT_SEL_WIDTH;
    localparam int unsigned OP_WIDTH  = ALU_FUN_WIDTH - UNIT_SEL_WIDTH;
    // One extra bit over what TIMEOUT_CYCLES-1 needs, so the counter never wraps.
    localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]                r_state;
    logic [NUM_UNITS-1:0]      r_unit_enable;
    logic [OP_WIDTH-1:0]       r_unit_op;
    logic [CNT_WIDTH-1:0]      r_cnt;
    logic                      r_out_valid;
    logic                      r_timeout_err;
    logic                      r_illegal_op;

    logic [1:0]                w_state_nxt;
    logic [NUM_UNITS-1:0]      w_unit_enable_nxt;
    logic [OP_WIDTH-1:0]       w_unit_op_nxt;
    logic [CNT_WIDTH-1:0]      w_cnt_nxt;
    logic                      w_out_valid_nxt;
    logic                      w_timeout_err_nxt;
    logic                      w_illegal_op_nxt;

    logic [UNIT_SEL_WIDTH-1:0] w_sel;
    logic [OP_WIDTH-1:0]       w_sub_op;
    logic [NUM_UNITS-1:0]      w_sel_onehot;
    logic                      w_permit;
    logic                      w_done_hit;
    logic                      w_cnt_last;

    assign w_sel        = ALU_FUN[ALU_FUN_WIDTH-1 -: UNIT_SEL_WIDTH];
    assign w_sub_op     = ALU_FUN[OP_WIDTH-1:0];
    assign w_sel_onehot = NUM_UNITS'(1) << w_sel;
    assign w_permit     = Enable_Mask[w_sel];

    // Unit_Enable is one-hot on the captured unit while busy, so masking with it
    // looks only at the selected unit's done bit and ignores all others.
    assign w_done_hit   = |(Unit_Done & r_unit_enable);
    assign w_cnt_last   = (r_cnt == CNT_LAST);

    always_comb begin
        w_state_nxt       = r_state;
        w_unit_enable_nxt = r_unit_enable;
        w_unit_op_nxt     = r_unit_op;
        w_cnt_nxt         = r_cnt;
        w_out_valid_nxt   = 1'b0;
        w_timeout_err_nxt = 1'b0;
        w_illegal_op_nxt  = 1'b0;

        case (r_state)
            StIdle: begin
                if (ALU_EN) begin
                    if (w_permit) begin
                        w_state_nxt       = StIssue;
                        w_unit_enable_nxt = w_sel_onehot;
                        w_unit_op_nxt     = w_sub_op;
                    end else begin
                        w_illegal_op_nxt  = 1'b1;
                    end
                end
            end

            // Unit gets one cycle of enable before its done line is trusted.
            StIssue: begin
                w_cnt_nxt   = '0;
                w_state_nxt = StWait;
            end

            StWait: begin
                if (w_done_hit) begin
                    // Completion takes priority over a coincident timeout.
                    w_state_nxt       = StDone;
                    w_unit_enable_nxt = '0;
                    w_out_valid_nxt   = 1'b1;
                end else if (w_cnt_last) begin
                    w_state_nxt       = StDone;
                    w_unit_enable_nxt = '0;
                    w_timeout_err_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
                end
            end

            StDone: begin
                w_state_nxt = StIdle;
            end

            default: begin
                w_state_nxt       = StIdle;
                w_unit_enable_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state       <= StIdle;
            r_unit_enable <= '0;
            r_unit_op     <= '0;
            r_cnt         <= '0;
            r_out_valid   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_illegal_op  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_unit_enable <= w_unit_enable_nxt;
            r_unit_op     <= w_unit_op_nxt;
            r_cnt         <= w_cnt_nxt;
            r_out_valid   <= w_out_valid_nxt;
            r_timeout_err <= w_timeout_err_nxt;
            r_illegal_op  <= w_illegal_op_nxt;
        end
    end

    assign Req_Ready   = (r_state == StIdle);
    assign Unit_Enable = r_unit_enable;
    assign Unit_OP     = r_unit_op;
    assign OUT_VALID   = r_out_valid;
    assign Timeout_Err = r_timeout_err;
    assign Illegal_Op  = r_illegal_op;

endmodule

// File: tb/tb_alu_dispatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_dispatch_ctrl
//
// Scoreboard bench: each issued request pushes its expected outcome (pulse kind
// and the cycle it must appear in) into a queue; a monitor pops and compares
// whenever the DUT raises a pulse, and also tracks Req_Ready / Unit_Enable /
// Unit_OP every cycle against expectations maintained by the stimulus side.
// -----------------------------------------------------------------------------
module tb_alu_dispatch_ctrl;

    localparam int T = 8;

    localparam int KValid   = 0;
    localparam int KTimeout = 1;
    localparam int KIllegal = 2;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] ALU_FUN;
    logic       ALU_EN;
    logic [3:0] Enable_Mask;
    logic [3:0] Unit_Done;
    logic       Req_Ready;
    logic [3:0] Unit_Enable;
    logic [1:0] Unit_OP;
    logic       OUT_VALID;
    logic       Timeout_Err;
    logic       Illegal_Op;

    alu_dispatch_ctrl #(
        .ALU_FUN_WIDTH  (4),
        .UNIT_SEL_WIDTH (2),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ALU_FUN     (ALU_FUN),
        .ALU_EN      (ALU_EN),
        .Enable_Mask (Enable_Mask),
        .Unit_Done   (Unit_Done),
        .Req_Ready   (Req_Ready),
        .Unit_Enable (Unit_Enable),
        .Unit_OP     (Unit_OP),
        .OUT_VALID   (OUT_VALID),
        .Timeout_Err (Timeout_Err),
        .Illegal_Op  (Illegal_Op)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int at_cyc;
    } exp_t;

    exp_t       sbq[$];
    logic [3:0] exp_ue  = 4'b0;
    logic [1:0] exp_op  = 2'b0;
    logic       exp_rdy = 1'b1;
    logic       mon_en  = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: sample 1 time unit after each rising edge.
    logic [2:0] pulses;
    int         got_kind;
    exp_t       e;
    always @(posedge CLK) begin
        #1;
        if (mon_en && RST) begin
            check("req_ready", 32'(Req_Ready), 32'(exp_rdy));
            check("unit_enable", 32'(Unit_Enable), 32'(exp_ue));
            if (exp_ue != 4'b0) check("unit_op", 32'(Unit_OP), 32'(exp_op));
            pulses = {OUT_VALID, Timeout_Err, Illegal_Op};
            if (pulses != 3'b0) begin
                check("pulse_onehot", 32'($onehot(pulses)), 32'd1);
                got_kind = OUT_VALID ? KValid : (Timeout_Err ? KTimeout : KIllegal);
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got kind %0d expected none (cycle %0d)",
                             got_kind, cyc);
                end else begin
                    e = sbq.pop_front();
                    check("pulse_kind", 32'(got_kind), 32'(e.kind));
                    check("pulse_cycle", 32'(cyc), 32'(e.at_cyc));
                end
            end else if (sbq.size() > 0 && sbq[0].at_cyc <= cyc) begin
                e = sbq.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_pulse: got none expected kind %0d at cycle %0d (now %0d)",
                         e.kind, e.at_cyc, cyc);
            end
        end
    end

    // Wait (bounded) for a negedge with Req_Ready high.
    task automatic wait_ready();
        int w;
        w = 0;
        @(negedge CLK);
        while (!Req_Ready && w < 30) begin
            @(negedge CLK);
            w++;
        end
        if (w >= 30) begin
            checks++;
            errors++;
            $display("FAIL ready_wait: got Req_Ready=0 expected 1 within 30 cycles");
        end
    endtask

    // One request. k = WAIT cycle (1-based) in which the selected unit reports
    // done; k outside 1..T means it never does. junk drives random ALU_EN /
    // ALU_FUN / Enable_Mask while busy, all of which must be ignored.
    task automatic do_op(input logic [3:0] fun, input logic [3:0] mask, input int k,
                         input bit junk);
        int         n;
        int         keff;
        int         kind;
        int         j;
        logic [1:0] sel;
        logic [3:0] dn;
        exp_t       x;

        sel = fun[3:2];
        wait_ready();
        n           = cyc + 1;
        ALU_FUN     = fun;
        ALU_EN      = 1'b1;
        Enable_Mask = mask;
        Unit_Done   = 4'($urandom);

        if (!mask[sel]) begin
            x.kind   = KIllegal;
            x.at_cyc = n;
            sbq.push_back(x);
            exp_ue  = 4'b0;
            exp_rdy = 1'b1;
            return;
        end

        if (k >= 1 && k <= T) begin
            keff = k;
            kind = KValid;
        end else begin
            keff = T;
            kind = KTimeout;
        end
        x.kind   = kind;
        x.at_cyc = n + 1 + keff;
        sbq.push_back(x);
        exp_ue  = 4'b1 << sel;
        exp_op  = fun[1:0];
        exp_rdy = 1'b0;

        // j = 0 is the ISSUE cycle, j >= 1 are WAIT cycles.
        for (j = 0; j <= keff; j++) begin
            @(negedge CLK);
            if (junk) begin
                ALU_EN      = 1'($urandom);
                ALU_FUN     = 4'($urandom);
                Enable_Mask = 4'($urandom);
            end else begin
                ALU_EN = 1'b0;
            end
            dn = 4'($urandom);
            if (j >= 1) dn[sel] = (kind == KValid) && (j >= k);
            Unit_Done = dn;
            if (j == keff) exp_ue = 4'b0;
        end
        // DONE cycle
        @(negedge CLK);
        ALU_EN    = 1'b0;
        Unit_Done = 4'($urandom);
        exp_rdy   = 1'b1;
    endtask

    initial begin
        RST         = 1'b0;
        ALU_FUN     = 4'b0;
        ALU_EN      = 1'b0;
        Enable_Mask = 4'b0;
        Unit_Done   = 4'b0;

        #3;
        check("rst_ready", 32'(Req_Ready), 32'd1);
        check("rst_unit_enable", 32'(Unit_Enable), 32'd0);
        check("rst_unit_op", 32'(Unit_OP), 32'd0);
        check("rst_pulses", 32'({OUT_VALID, Timeout_Err, Illegal_Op}), 32'd0);
        repeat (2) @(negedge CLK);
        RST     = 1'b1;
        exp_ue  = 4'b0;
        exp_rdy = 1'b1;
        mon_en  = 1'b1;

        do_op(4'b1001, 4'b1111, 3, 1'b0);   // unit 2, done in 3rd WAIT cycle
        do_op(4'b1110, 4'b1111, 0, 1'b0);   // unit 3, timeout
        do_op(4'b0011, 4'b1110, 0, 1'b0);   // unit 0 masked
        do_op(4'b1100, 4'b1111, 8, 1'b0);   // done and timeout coincide
        do_op(4'b0101, 4'b1111, 5, 1'b1);   // new requests while busy
        do_op(4'b0000, 4'b0001, 1, 1'b1);   // minimum latency
        do_op(4'b0111, 4'b1101, 2, 1'b0);   // masked, back to back
        do_op(4'b1011, 4'b1011, 0, 1'b0);   // masked, back to back

        // Reset during WAIT on unit 1: abort silently.
        wait_ready();
        ALU_FUN     = 4'b0110;
        ALU_EN      = 1'b1;
        Enable_Mask = 4'b1111;
        Unit_Done   = 4'b0;
        exp_ue      = 4'b0010;
        exp_op      = 2'b10;
        exp_rdy     = 1'b0;
        @(negedge CLK);
        ALU_EN = 1'b0;
        repeat (2) @(negedge CLK);
        #2;
        mon_en = 1'b0;
        RST    = 1'b0;
        #1;
        check("arst_unit_enable", 32'(Unit_Enable), 32'd0);
        check("arst_ready", 32'(Req_Ready), 32'd1);
        check("arst_pulses", 32'({OUT_VALID, Timeout_Err, Illegal_Op}), 32'd0);
        exp_ue  = 4'b0;
        exp_rdy = 1'b1;
        repeat (2) @(negedge CLK);
        RST    = 1'b1;
        mon_en = 1'b1;
        do_op(4'b0110, 4'b1111, 2, 1'b0);   // dispatches normally after release

        for (int i = 0; i < 80; i++) begin
            do_op(4'($urandom), 4'($urandom), int'($urandom_range(0, 11)), 1'($urandom));
        end

        @(negedge CLK);
        ALU_EN = 1'b0;
        repeat (4) @(negedge CLK);
        check("queue_drained", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
